// File: rtl/bcd_mod_timer.sv
// Multi-digit BCD counter with programmable modulus, up/down/one-shot modes,
// parallel load with clamping, and registered wrap/done pulses for cascading.
module bcd_mod_timer #(
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 59
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [1:0]            mode,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic                  done,
    output logic                  running,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic [W-1:0] to_bcd(input int val);
        int           v;
        logic [W-1:0] r;
        v = val;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);
    localparam logic [W-1:0] ONE_BCD = to_bcd(1);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // With every digit valid, a plain unsigned compare orders BCD values correctly.
    function automatic logic bcd_legal(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok && (v <= MAX_BCD);
    endfunction

    state_t        state, state_d;
    logic [W-1:0]  count_d;
    logic          wrap_d, done_d, err_d;

    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = load_err;
        state_d = state;

        if (clr) begin
            count_d = '0;
            err_d   = 1'b0;
            state_d = IDLE;
        end else if (load) begin
            if (bcd_legal(load_val)) begin
                count_d = load_val;
                err_d   = 1'b0;
            end else begin
                count_d = MAX_BCD;
                err_d   = 1'b1;
            end
            if (mode == MODE_ONE && count_d != '0) state_d = RUN;
            else                                   state_d = IDLE;
        end else begin
            if (mode != MODE_ONE) state_d = IDLE;
            if (tick) begin
                case (mode)
                    MODE_UP: begin
                        if (count == MAX_BCD) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = bcd_inc(count);
                        end
                    end
                    MODE_DOWN: begin
                        if (count == '0) begin
                            count_d = MAX_BCD;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = bcd_dec(count);
                        end
                    end
                    MODE_ONE: begin
                        // Only RUN counts; IDLE and DONE hold the value.
                        if (state == RUN) begin
                            if (count <= ONE_BCD) begin
                                count_d = '0;
                                done_d  = 1'b1;
                                state_d = DONE;
                            end else begin
                                count_d = bcd_dec(count);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            running  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            wrap     <= wrap_d;
            done     <= done_d;
            running  <= (state_d == RUN);
            load_err <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_mod_timer.sv
// Directed testbench for bcd_mod_timer: a 2-digit 00..59 instance and a
// 3-digit 000..199 instance, checked against hand-computed BCD values.
module tb_bcd_mod_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        tick, clr, load;
    logic [7:0]  load_val;
    logic [1:0]  mode;
    logic [7:0]  count;
    logic        wrap, done, running, load_err;

    logic        tick3, clr3, load3;
    logic [11:0] load_val3;
    logic [1:0]  mode3;
    logic [11:0] count3;
    logic        wrap3, done3, running3, load_err3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    bcd_mod_timer #(.DIGITS(2), .MAX_VAL(59)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .clr(clr), .load(load),
        .load_val(load_val), .mode(mode), .count(count), .wrap(wrap),
        .done(done), .running(running), .load_err(load_err)
    );

    bcd_mod_timer #(.DIGITS(3), .MAX_VAL(199)) dut3 (
        .clk(clk), .rst(rst), .tick(tick3), .clr(clr3), .load(load3),
        .load_val(load_val3), .mode(mode3), .count(count3), .wrap(wrap3),
        .done(done3), .running(running3), .load_err(load_err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick = 0; clr = 0; load = 0; load_val = 8'h00; mode = 2'b00;
        tick3 = 0; clr3 = 0; load3 = 0; load_val3 = 12'h000; mode3 = 2'b00;
        rst = 1'b0;
        #12;
        vectors++;
        if ({count, wrap, done, running, load_err} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset2 got %h/%b%b%b%b want 00/0000", count, wrap, done, running, load_err);
        end
        vectors++;
        if ({count3, wrap3, done3, running3, load_err3} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset3 got %h/%b%b%b%b want 000/0000", count3, wrap3, done3, running3, load_err3);
        end
        step();
        rst = 1'b1;
        step();
        vectors++;
        if ({count, wrap, done, running, load_err} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL post_reset got %h/%b%b%b%b want 00/0000", count, wrap, done, running, load_err);
        end
    endtask

    task automatic test_up_wrap();
        int           v;
        logic [7:0]   exp_cnt;
        mode = 2'b00;
        tick = 1;
        for (int k = 1; k <= 60; k++) begin
            step();
            v       = k % 60;
            exp_cnt = {4'(v / 10), 4'(v % 10)};
            vectors++;
            if ({count, wrap, done, running} !== {exp_cnt, (k == 60), 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL up_wrap k=%0d got %h wrap=%b want %h wrap=%b", k, count, wrap, exp_cnt, (k == 60));
            end
        end
        tick = 0;
    endtask

    task automatic test_down_wrap();
        int           v;
        logic [7:0]   exp_cnt;
        mode = 2'b01;
        load = 1; load_val = 8'h10;
        step();
        load = 0;
        vectors++;
        if ({count, load_err} !== {8'h10, 1'b0}) begin
            errors++;
            $display("[TB] FAIL down_load got %h err=%b want 10 err=0", count, load_err);
        end
        tick = 1;
        for (int k = 1; k <= 11; k++) begin
            step();
            v       = (k <= 10) ? 10 - k : 59;
            exp_cnt = {4'(v / 10), 4'(v % 10)};
            vectors++;
            if ({count, wrap} !== {exp_cnt, (k == 11)}) begin
                errors++;
                $display("[TB] FAIL down_wrap k=%0d got %h wrap=%b want %h wrap=%b", k, count, wrap, exp_cnt, (k == 11));
            end
        end
        tick = 0;
    endtask

    task automatic test_one_shot();
        logic [7:0] exp_cnt [5];
        logic [4:0] exp_done;
        logic [4:0] exp_run;
        exp_cnt  = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
        exp_done = 5'b00100;
        exp_run  = 5'b11000;
        mode = 2'b10;
        load = 1; load_val = 8'h03;
        step();
        load = 0;
        vectors++;
        if ({count, running, done} !== {8'h03, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL oneshot_load got %h run=%b done=%b want 03 run=1 done=0", count, running, done);
        end
        tick = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if ({count, done, running, wrap} !== {exp_cnt[k], exp_done[4-k], exp_run[4-k], 1'b0}) begin
                errors++;
                $display("[TB] FAIL oneshot k=%0d got %h d=%b r=%b w=%b want %h d=%b r=%b w=0",
                         k, count, done, running, wrap, exp_cnt[k], exp_done[4-k], exp_run[4-k]);
            end
        end
        tick = 0;
        load = 1; load_val = 8'h00;
        step();
        load = 0;
        vectors++;
        if ({count, done, running} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL oneshot_zero got %h d=%b r=%b want 00 d=0 r=0", count, done, running);
        end
    endtask

    task automatic test_load_err();
        logic [7:0] vals [3];
        logic [7:0] exp_cnt [3];
        logic [2:0] exp_err;
        vals    = '{8'h7A, 8'h42, 8'h60};
        exp_cnt = '{8'h59, 8'h42, 8'h59};
        exp_err = 3'b101;
        mode = 2'b11;
        for (int k = 0; k < 3; k++) begin
            load = 1; load_val = vals[k];
            step();
            load = 0;
            vectors++;
            if ({count, load_err} !== {exp_cnt[k], exp_err[2-k]}) begin
                errors++;
                $display("[TB] FAIL load_err val=%h got %h err=%b want %h err=%b",
                         vals[k], count, load_err, exp_cnt[k], exp_err[2-k]);
            end
        end
        tick = 1;
        step();
        tick = 0;
        vectors++;
        if ({count, load_err, wrap} !== {8'h59, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL hold got %h err=%b w=%b want 59 err=1 w=0", count, load_err, wrap);
        end
        clr = 1;
        step();
        clr = 0;
        vectors++;
        if ({count, load_err} !== {8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clr got %h err=%b want 00 err=0", count, load_err);
        end
    endtask

    task automatic test_priority();
        mode = 2'b00;
        load = 1; load_val = 8'h30;
        step();
        load = 1; tick = 1; load_val = 8'h15;
        step();
        load = 0;
        vectors++;
        if ({count, wrap} !== {8'h15, 1'b0}) begin
            errors++;
            $display("[TB] FAIL load_tick got %h w=%b want 15 w=0", count, wrap);
        end
        step();
        vectors++;
        if (count !== 8'h16) begin
            errors++;
            $display("[TB] FAIL tick_after_load got %h want 16", count);
        end
        clr = 1; load = 1; load_val = 8'h42;
        step();
        clr = 0; load = 0; tick = 0;
        vectors++;
        if ({count, wrap, load_err} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clr_load got %h w=%b err=%b want 00 w=0 err=0", count, wrap, load_err);
        end
    endtask

    task automatic test_mode_change();
        mode = 2'b10;
        load = 1; load_val = 8'h05;
        step();
        load = 0;
        mode = 2'b00;
        step();
        vectors++;
        if ({count, running} !== {8'h05, 1'b0}) begin
            errors++;
            $display("[TB] FAIL leave_oneshot got %h r=%b want 05 r=0", count, running);
        end
        tick = 1;
        step();
        vectors++;
        if (count !== 8'h06) begin
            errors++;
            $display("[TB] FAIL up_after_mode got %h want 06", count);
        end
        mode = 2'b10;
        step();
        tick = 0;
        vectors++;
        if ({count, running, done} !== {8'h06, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL oneshot_idle got %h r=%b d=%b want 06 r=0 d=0", count, running, done);
        end
    endtask

    task automatic test_three_digit();
        mode3 = 2'b00;
        load3 = 1; load_val3 = 12'h099;
        step();
        load3 = 0; tick3 = 1;
        step();
        tick3 = 0;
        vectors++;
        if ({count3, wrap3} !== {12'h100, 1'b0}) begin
            errors++;
            $display("[TB] FAIL carry3 got %h w=%b want 100 w=0", count3, wrap3);
        end
        load3 = 1; load_val3 = 12'h199;
        step();
        load3 = 0; tick3 = 1;
        step();
        vectors++;
        if ({count3, wrap3} !== {12'h000, 1'b1}) begin
            errors++;
            $display("[TB] FAIL wrap3 got %h w=%b want 000 w=1", count3, wrap3);
        end
        step(); step(); step();
        tick3 = 0;
        vectors++;
        if ({count3, wrap3} !== {12'h003, 1'b0}) begin
            errors++;
            $display("[TB] FAIL count3 got %h w=%b want 003 w=0", count3, wrap3);
        end
        mode = 2'b10;
        load = 1; load_val = 8'h7A;
        step();
        load = 0;
        vectors++;
        if ({count, running, load_err} !== {8'h59, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL pre_reset got %h r=%b err=%b want 59 r=1 err=1", count, running, load_err);
        end
        #3;
        rst = 1'b0;
        #1;
        vectors++;
        if ({count3, wrap3, done3, running3, load_err3} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL async_rst3 got %h/%b%b%b%b want 000/0000", count3, wrap3, done3, running3, load_err3);
        end
        vectors++;
        if ({count, wrap, done, running, load_err} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL async_rst2 got %h/%b%b%b%b want 00/0000", count, wrap, done, running, load_err);
        end
        step();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_one_shot();
        test_load_err();
        test_priority();
        test_mode_change();
        test_three_digit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
